// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci stream generator/checker pair:
// checker state encoding and the sequence seed constants.
package fib_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fib_state_e;

  localparam int FIB_SEED0 = 0;
  localparam int FIB_SEED1 = 1;

endpackage

// File: rtl/fib_ref_seq.sv
// Reference Fibonacci term pair (ref_a = current term, ref_b = next term),
// modulo 2^WIDTH, with a carry flag for the pending advance sum.
module fib_ref_seq
  import fib_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             advance,
  output logic [WIDTH-1:0] ref_a,
  output logic             carry
);

  localparam logic [WIDTH-1:0] SEED0 = WIDTH'(FIB_SEED0);
  localparam logic [WIDTH-1:0] SEED1 = WIDTH'(FIB_SEED1);

  logic [WIDTH-1:0] ref_b;
  logic [WIDTH-1:0] sum;

  // carry reports the overflow of the sum that the next advance would store
  assign {carry, sum} = {1'b0, ref_a} + {1'b0, ref_b};

  always_ff @(posedge clk) begin
    if (reset || load) begin
      ref_a <= SEED0;
      ref_b <= SEED1;
    end else if (advance) begin
      ref_a <= ref_b;
      ref_b <= sum;
    end
  end

endmodule

// File: rtl/fib_stream_checker.sv
// Receive-side Fibonacci stream checker: compares accepted terms with an
// internal reference and reports pass/errors/overflow after n_terms.
// Optional mismatch capture outputs are enabled by FIB_CHK_CAPTURE_EN.
module fib_stream_checker
  import fib_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] n_terms,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] first_err_idx,
  output logic             ovf
`ifdef FIB_CHK_CAPTURE_EN
  ,
  output logic [WIDTH-1:0] err_exp,
  output logic [WIDTH-1:0] err_got
`endif
);

  fib_state_e       state;
  fib_state_e       state_nxt;
  logic [CNT_W-1:0] n_lat;
  logic [CNT_W-1:0] idx;
  logic [CNT_W-1:0] err_nxt;
  logic [WIDTH-1:0] ref_a;
  logic             ref_carry;
  logic             start_ok;
  logic             accept;
  logic             mismatch;
  logic             last;

  // Handshake: a term transfers on any cycle where in_valid && in_ready;
  // in_ready depends only on registered state, never on in_valid.
  assign in_ready = (state == RUN);
  assign busy     = (state == RUN);
  assign done     = (state == DONE);

  assign start_ok = start && (state != RUN);
  assign accept   = in_valid && in_ready;
  assign mismatch = accept && (in_data != ref_a);
  assign last     = accept && (idx == n_lat - 1'b1);
  assign err_nxt  = (mismatch && !(&err_count)) ? err_count + 1'b1 : err_count;

  fib_ref_seq #(.WIDTH(WIDTH)) u_ref (
    .clk     (clk),
    .reset   (reset),
    .load    (start_ok),
    .advance (accept),
    .ref_a   (ref_a),
    .carry   (ref_carry)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = (n_terms == '0) ? DONE : RUN;
      RUN:        if (last) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      n_lat         <= '0;
      idx           <= '0;
      err_count     <= '0;
      first_err_idx <= '0;
      ovf           <= 1'b0;
      pass          <= 1'b0;
    end else if (start_ok) begin
      n_lat         <= n_terms;
      idx           <= '0;
      err_count     <= '0;
      first_err_idx <= '0;
      ovf           <= 1'b0;
      pass          <= (n_terms == '0);
    end else if (accept) begin
      idx       <= idx + 1'b1;
      err_count <= err_nxt;
      if (mismatch && (err_count == '0)) first_err_idx <= idx;
      if (ref_carry) ovf <= 1'b1;
      // err_nxt folds in a mismatch on the final term itself
      if (last) pass <= (err_nxt == '0);
    end
  end

`ifdef FIB_CHK_CAPTURE_EN
  always_ff @(posedge clk) begin
    if (reset || start_ok) begin
      err_exp <= '0;
      err_got <= '0;
    end else if (mismatch && (err_count == '0)) begin
      err_exp <= ref_a;
      err_got <= in_data;
    end
  end
`endif

endmodule
